// File: rtl/lsu_datos.sv
// Load/store unit driving a byte-addressed, big-endian, word-wide data memory.
// Byte stores go through read-modify-write; byte loads are lane-extracted and extended.
module lsu_datos #(
    parameter int unsigned MEM_BYTES   = 24,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic              i_req_byte,
    input  logic              i_req_sext,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam int unsigned WORD_MAX = MEM_BYTES - 4;
    localparam int unsigned BYTE_MAX = MEM_BYTES - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t            r_state;
    logic              r_we;
    logic              r_byte;
    logic              r_sext;
    logic [1:0]        r_lane;
    logic [7:0]        r_wbyte;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [31:0]       r_mem_wdata;

    state_t            w_nxt_state;
    logic              w_nxt_we;
    logic              w_nxt_byte;
    logic              w_nxt_sext;
    logic [1:0]        w_nxt_lane;
    logic [7:0]        w_nxt_wbyte;
    logic              w_nxt_req_ready;
    logic              w_nxt_rsp_valid;
    logic              w_nxt_rsp_err;
    logic [31:0]       w_nxt_rsp_rdata;
    logic [ADDR_W-1:0] w_nxt_mem_addr;
    logic              w_nxt_mem_we;
    logic [31:0]       w_nxt_mem_wdata;

    logic [31:0]       w_addr_ext;
    logic [ADDR_W-1:0] w_byte_base;
    logic [ADDR_W-1:0] w_base;
    logic [1:0]        w_lane;
    logic              w_err;
    logic              w_accept;
    logic [7:0]        w_lane_byte;
    logic [31:0]       w_merged;
    logic [31:0]       w_load_byte;

    // Request decode: byte accesses near the top clamp the base so the 4-byte window stays in range
    always_comb begin
        w_addr_ext  = 32'(i_req_addr);
        w_byte_base = (w_addr_ext > WORD_MAX) ? ADDR_W'(WORD_MAX) : i_req_addr;
        w_lane      = 2'(i_req_addr - w_byte_base);
        w_base      = i_req_byte ? w_byte_base : i_req_addr;
        if (i_req_byte) begin
            w_err = (w_addr_ext > BYTE_MAX);
        end else begin
            w_err = (w_addr_ext > WORD_MAX) ||
                    ((ALIGN_CHECK != 0) && (i_req_addr[1:0] != 2'b00));
        end
        w_accept = i_req_valid && r_req_ready;
    end

    // Lane select and merge; lane 0 is the most significant byte
    always_comb begin
        w_lane_byte = i_mem_rdata[31:24];
        w_merged    = i_mem_rdata;
        case (r_lane)
            2'd0: begin
                w_lane_byte = i_mem_rdata[31:24];
                w_merged    = {r_wbyte, i_mem_rdata[23:0]};
            end
            2'd1: begin
                w_lane_byte = i_mem_rdata[23:16];
                w_merged    = {i_mem_rdata[31:24], r_wbyte, i_mem_rdata[15:0]};
            end
            2'd2: begin
                w_lane_byte = i_mem_rdata[15:8];
                w_merged    = {i_mem_rdata[31:16], r_wbyte, i_mem_rdata[7:0]};
            end
            default: begin
                w_lane_byte = i_mem_rdata[7:0];
                w_merged    = {i_mem_rdata[31:8], r_wbyte};
            end
        endcase
        w_load_byte = {{24{r_sext & w_lane_byte[7]}}, w_lane_byte};
    end

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_we        = r_we;
        w_nxt_byte      = r_byte;
        w_nxt_sext      = r_sext;
        w_nxt_lane      = r_lane;
        w_nxt_wbyte     = r_wbyte;
        w_nxt_req_ready = r_req_ready;
        w_nxt_rsp_valid = r_rsp_valid;
        w_nxt_rsp_err   = r_rsp_err;
        w_nxt_rsp_rdata = r_rsp_rdata;
        w_nxt_mem_addr  = '0;
        w_nxt_mem_we    = 1'b0;
        w_nxt_mem_wdata = r_mem_wdata;

        case (r_state)
            ST_IDLE: begin
                w_nxt_req_ready = 1'b1;
                if (w_accept) begin
                    w_nxt_we        = i_req_we;
                    w_nxt_byte      = i_req_byte;
                    w_nxt_sext      = i_req_sext;
                    w_nxt_lane      = w_lane;
                    w_nxt_wbyte     = i_req_wdata[7:0];
                    w_nxt_req_ready = 1'b0;
                    w_nxt_rsp_rdata = '0;
                    if (w_err) begin
                        w_nxt_state     = ST_RESP;
                        w_nxt_rsp_valid = 1'b1;
                        w_nxt_rsp_err   = 1'b1;
                    end else begin
                        w_nxt_state    = ST_ACCESS;
                        w_nxt_mem_addr = w_base;
                        if (i_req_we && !i_req_byte) begin
                            w_nxt_mem_we    = 1'b1;
                            w_nxt_mem_wdata = i_req_wdata;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (r_we && r_byte) begin
                    w_nxt_state     = ST_WRITE;
                    w_nxt_mem_addr  = r_mem_addr;
                    w_nxt_mem_we    = 1'b1;
                    w_nxt_mem_wdata = w_merged;
                end else begin
                    w_nxt_state     = ST_RESP;
                    w_nxt_rsp_valid = 1'b1;
                    if (!r_we) begin
                        w_nxt_rsp_rdata = r_byte ? w_load_byte : i_mem_rdata;
                    end
                end
            end
            ST_WRITE: begin
                w_nxt_state     = ST_RESP;
                w_nxt_rsp_valid = 1'b1;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_nxt_state     = ST_IDLE;
                    w_nxt_rsp_valid = 1'b0;
                    w_nxt_rsp_err   = 1'b0;
                    w_nxt_req_ready = 1'b1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_byte      <= 1'b0;
            r_sext      <= 1'b0;
            r_lane      <= 2'd0;
            r_wbyte     <= 8'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_we        <= w_nxt_we;
            r_byte      <= w_nxt_byte;
            r_sext      <= w_nxt_sext;
            r_lane      <= w_nxt_lane;
            r_wbyte     <= w_nxt_wbyte;
            r_req_ready <= w_nxt_req_ready;
            r_rsp_valid <= w_nxt_rsp_valid;
            r_rsp_err   <= w_nxt_rsp_err;
            r_rsp_rdata <= w_nxt_rsp_rdata;
            r_mem_addr  <= w_nxt_mem_addr;
            r_mem_we    <= w_nxt_mem_we;
            r_mem_wdata <= w_nxt_mem_wdata;
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_datos.sv
// Directed bench for lsu_datos with a 24-byte big-endian memory model.
module tb_lsu_datos;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_sext = 1'b0;
    logic [4:0]  req_addr = 5'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [7:0]  mem [24];
    int          checks = 0;
    int          errors = 0;
    int          we_total = 0;
    logic [4:0]  last_we_addr = 5'd0;
    logic [31:0] last_we_data = 32'd0;

    always #5 clk = ~clk;

    lsu_datos #(.MEM_BYTES(24), .ADDR_W(5), .ALIGN_CHECK(1)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_byte  (req_byte),
        .i_req_sext  (req_sext),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Memory model: combinational big-endian read, write on the rising edge
    always_comb begin
        int a;
        a = int'(mem_addr);
        mem_rdata = 32'd0;
        if (a + 3 < 24) mem_rdata = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    end

    always @(posedge clk) begin
        int a;
        a = int'(mem_addr);
        if (mem_we === 1'b1 && a + 3 < 24) begin
            mem[a]   <= mem_wdata[31:24];
            mem[a+1] <= mem_wdata[23:16];
            mem[a+2] <= mem_wdata[15:8];
            mem[a+3] <= mem_wdata[7:0];
        end
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_total     <= we_total + 1;
            last_we_addr <= mem_addr;
            last_we_data <= mem_wdata;
        end
    end

    // Issue one request and wait (bounded) for its response; lat counts cycles after the accept edge
    task automatic issue(input logic we, input logic byt, input logic sext, input logic [4:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int wec);
        int n;
        @(negedge clk);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_we = we; req_byte = byt; req_sext = sext;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        lat = 0;
        wec = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (mem_we === 1'b1) wec++;
        end while (rsp_valid !== 1'b1 && lat < 20);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got v=%b e=%b exp 0 0", rsp_valid, rsp_err); end
        checks++; if (rsp_rdata !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_data got rd=%h wd=%h exp 0", rsp_rdata, mem_wdata); end
        checks++; if (mem_addr !== 5'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem got a=%h we=%b exp 0 0", mem_addr, mem_we); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; int wec;
        issue(1'b1, 1'b0, 1'b0, 5'd4, 32'hDEADBEEF, rd, er, lat, wec);
        checks++; if (er !== 1'b0 || lat != 2) begin errors++; $display("FAIL wstore_resp got err=%b lat=%0d exp 0 2", er, lat); end
        checks++; if (wec != 1 || last_we_addr !== 5'd4 || last_we_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wstore_mem got n=%0d a=%h d=%h exp 1 04 deadbeef", wec, last_we_addr, last_we_data); end
        issue(1'b0, 1'b0, 1'b0, 5'd4, 32'd0, rd, er, lat, wec);
        checks++; if (rd !== 32'hDEADBEEF || lat != 2 || wec != 0) begin errors++; $display("FAIL wload got rd=%h lat=%0d we=%0d exp deadbeef 2 0", rd, lat, wec); end
    endtask

    task automatic test_byte_load();
        logic [31:0] rd; logic er; int lat; int wec;
        issue(1'b0, 1'b1, 1'b0, 5'd5, 32'd0, rd, er, lat, wec);
        checks++; if (rd !== 32'h000000AD || lat != 2) begin errors++; $display("FAIL bload_zext got rd=%h lat=%0d exp 000000ad 2", rd, lat); end
        issue(1'b0, 1'b1, 1'b1, 5'd5, 32'd0, rd, er, lat, wec);
        checks++; if (rd !== 32'hFFFFFFAD) begin errors++; $display("FAIL bload_sext got rd=%h exp ffffffad", rd); end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic er; int lat; int wec;
        issue(1'b1, 1'b0, 1'b0, 5'd20, 32'h11223344, rd, er, lat, wec);
        issue(1'b1, 1'b1, 1'b0, 5'd22, 32'hFFFFFF5A, rd, er, lat, wec);
        checks++; if (er !== 1'b0 || lat != 3 || wec != 1) begin errors++; $display("FAIL bstore_resp got err=%b lat=%0d we=%0d exp 0 3 1", er, lat, wec); end
        checks++; if (last_we_addr !== 5'd20 || last_we_data !== 32'h11225A44) begin errors++; $display("FAIL bstore_mem got a=%h d=%h exp 14 11225a44", last_we_addr, last_we_data); end
        issue(1'b0, 1'b0, 1'b0, 5'd20, 32'd0, rd, er, lat, wec);
        checks++; if (rd !== 32'h11225A44) begin errors++; $display("FAIL bstore_readback got %h exp 11225a44", rd); end
        issue(1'b1, 1'b1, 1'b0, 5'd23, 32'h00000077, rd, er, lat, wec);
        checks++; if (last_we_addr !== 5'd20 || last_we_data !== 32'h11225A77) begin errors++; $display("FAIL bstore_lane3 got a=%h d=%h exp 14 11225a77", last_we_addr, last_we_data); end
        issue(1'b0, 1'b1, 1'b1, 5'd23, 32'd0, rd, er, lat, wec);
        checks++; if (rd !== 32'h00000077) begin errors++; $display("FAIL bload_lane3_pos got %h exp 00000077", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; int wec; int base_we;
        base_we = we_total;
        issue(1'b1, 1'b0, 1'b0, 5'd21, 32'hCAFEF00D, rd, er, lat, wec);
        checks++; if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin errors++; $display("FAIL err_word_range got err=%b rd=%h lat=%0d exp 1 0 1", er, rd, lat); end
        issue(1'b0, 1'b0, 1'b0, 5'd2, 32'd0, rd, er, lat, wec);
        checks++; if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin errors++; $display("FAIL err_word_align got err=%b rd=%h lat=%0d exp 1 0 1", er, rd, lat); end
        issue(1'b1, 1'b1, 1'b0, 5'd24, 32'h000000AA, rd, er, lat, wec);
        checks++; if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin errors++; $display("FAIL err_byte_range got err=%b rd=%h lat=%0d exp 1 0 1", er, rd, lat); end
        @(negedge clk);
        checks++; if (we_total != base_we) begin errors++; $display("FAIL err_no_write got %0d writes exp 0", we_total - base_we); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int wec;
        rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 5'd20, 32'd0, rd, er, lat, wec);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11225A77 || req_ready !== 1'b0) begin errors++; $display("FAIL hold_%0d got v=%b rd=%h rdy=%b exp 1 11225a77 0", i, rsp_valid, rsp_rdata, req_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL release got v=%b rdy=%b exp 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; int wec; int base_we; int n;
        @(negedge clk);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_sext = 1'b0;
        req_addr = 5'd21; req_wdata = 32'h00000099;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd20) begin errors++; $display("FAIL write_phase got we=%b a=%h exp 1 14", mem_we, mem_addr); end
        rst_n = 1'b0;
        #1;
        base_we = we_total;
        checks++; if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || mem_addr !== 5'd0) begin errors++; $display("FAIL abort_outputs got we=%b v=%b a=%h exp 0 0 0", mem_we, rsp_valid, mem_addr); end
        repeat (3) @(negedge clk);
        checks++; if (we_total != base_we || rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet got writes=%0d v=%b exp 0 0", we_total - base_we, rsp_valid); end
        rst_n = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 5'd20, 32'd0, rd, er, lat, wec);
        checks++; if (rd !== 32'h11225A77 || er !== 1'b0) begin errors++; $display("FAIL abort_mem got rd=%h err=%b exp 11225a77 0", rd, er); end
    endtask

    initial begin
        for (int i = 0; i < 24; i++) mem[i] = 8'h00;
        test_reset();
        test_word();
        test_byte_load();
        test_byte_store();
        test_errors();
        test_backpressure();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
